// File: rtl/rsa_pkg.sv
// Shared types and sizing helpers for the RSA datapath blocks.
package rsa_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOOP = 2'd1,
    CORR = 2'd2,
    DONE = 2'd3
  } mmm_state_t;

  localparam int MMM_WIDTH_DEF = 8;
  localparam int MMM_CNT_W_DEF = $clog2(MMM_WIDTH_DEF);

  // Iteration counter width for a given operand width (WIDTH >= 2).
  function automatic int mmm_cnt_w(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/mmm_step.sv
// One radix-2 Montgomery iteration: P' = (P + a_i*b + q*m) / 2, q chosen to make the sum even.
// Purely combinational; P < 2m in gives P' < 2m out for legal operands.
module mmm_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   p,
  input  logic             a_bit,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH:0]   p_next
);

  logic [WIDTH+1:0] t;
  logic [WIDTH+1:0] s;
  logic             s_lsb_unused;

  assign t = {1'b0, p} + (a_bit ? {2'b00, b} : '0);
  assign s = t + (t[0] ? {2'b00, m} : '0);

  // s is even by construction, so dropping bit 0 is an exact halving.
  assign p_next       = s[WIDTH+1:1];
  assign s_lsb_unused = s[0];

endmodule

// File: rtl/mmm_unit.sv
// Bit-serial Montgomery multiplier, dout = a*b*2^-WIDTH mod m; done after WIDTH+2 edges (WIDTH+1 without
// MMM_FINAL_SUB_EN, which drops the final subtraction). start is only accepted in IDLE, otherwise ignored.
import rsa_pkg::*;

module mmm_unit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH-1:0] dout,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = mmm_cnt_w(WIDTH);

  mmm_state_t       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] m_q;
  logic [WIDTH-1:0] dout_q;
  logic [WIDTH:0]   p_q;
  logic [WIDTH:0]   p_step;
  logic             busy_q;
  logic             done_q;
  logic             last_iter;

  assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

  mmm_step #(.WIDTH(WIDTH)) u_step (
    .p      (p_q),
    .a_bit  (a_q[cnt_q]),
    .b      (b_q),
    .m      (m_q),
    .p_next (p_step)
  );

`ifdef MMM_FINAL_SUB_EN
  logic [WIDTH:0] p_corr;
  assign p_corr = (p_q >= {1'b0, m_q}) ? (p_q - {1'b0, m_q}) : p_q;
  localparam mmm_state_t AFTER_LOOP = CORR;
`else
  localparam mmm_state_t AFTER_LOOP = DONE;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      m_q     <= '0;
      p_q     <= '0;
      dout_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            m_q     <= m;
            p_q     <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= LOOP;
          end
        end
        LOOP: begin
          p_q <= p_step;
          if (last_iter) begin
            cnt_q   <= '0;
            state_q <= AFTER_LOOP;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
`ifdef MMM_FINAL_SUB_EN
        CORR: begin
          p_q     <= p_corr;
          state_q <= DONE;
        end
`endif
        DONE: begin
          dout_q  <= p_q[WIDTH-1:0];
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dout = dout_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_mmm_unit.sv
// Self-checking bench for mmm_unit (WIDTH=8): scoreboard of reference results against each done pulse.
module tb_mmm_unit;

  localparam int W = 8;
`ifdef MMM_FINAL_SUB_EN
  localparam int LAT = W + 2;
`else
  localparam int LAT = W + 1;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b, m;
  logic [W-1:0] dout;
  logic         busy, done;

  int n_chk  = 0;
  int n_fail = 0;
  logic [W-1:0] exp_q[$];

  mmm_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .m     (m),
    .dout  (dout),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: the unique x in [0,m) with x*2^W == a*b (mod m).
  function automatic logic [W-1:0] ref_mont(input int ia, input int ib, input int im);
    int ab;
    ab = (ia * ib) % im;
    for (int x = 0; x < im; x++)
      if (((x << W) % im) == ab) return W'(x);
    return '0;
  endfunction

  // Without the final subtraction the raw result may carry one extra m (truncated to W bits).
  function automatic logic [W-1:0] alt_of(input logic [W-1:0] e, input logic [W-1:0] im);
`ifdef MMM_FINAL_SUB_EN
    return e;
`else
    return W'(int'(e) + int'(im));
`endif
  endfunction

  task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic [W-1:0] im,
                        output logic [W-1:0] d, output int lat, output bit ok,
                        output logic busy0, output logic busy_at_done);
    @(negedge clk);
    a = ia; b = ib; m = im; start = 1'b1;
    exp_q.push_back(ref_mont(int'(ia), int'(ib), int'(im)));
    @(posedge clk); #1;
    start = 1'b0;
    busy0 = busy;
    lat = 0; ok = 1'b0; d = '0; busy_at_done = 1'b1;
    for (int k = 0; k < 40 && !ok; k++) begin
      @(posedge clk); #1;
      lat++;
      if (done) begin
        ok = 1'b1;
        d = dout;
        busy_at_done = busy;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; m = 8'd13;
    #1;
    n_chk++;
    if (dout !== 8'd0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async: dout=%0d busy=%b done=%b, required 0/0/0", dout, busy, done);
    end
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if (dout !== 8'd0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: dout=%0d busy=%b done=%b, required 0/0/0", dout, busy, done);
    end
  endtask

  task automatic test_basic;
    logic [W-1:0] d, e;
    int lat; bit ok; logic b0, bd;
    run_op(8'd5, 8'd7, 8'd13, d, lat, ok, b0, bd);
    e = exp_q.pop_front();
    n_chk++;
    if (!ok || lat != LAT) begin
      n_fail++;
      $display("FAIL basic_latency: done after %0d cycles (seen=%0d), required %0d", lat, ok, LAT);
    end
    n_chk++;
    if (d !== 8'd1 || e !== 8'd1) begin
      n_fail++;
      $display("FAIL basic_dout: dout=%0d, required 1 (model %0d)", d, e);
    end
    n_chk++;
    if (b0 !== 1'b1 || bd !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_busy: busy after start=%b, at done=%b, required 1/0", b0, bd);
    end
  endtask

  task automatic test_final_sub;
    logic [W-1:0] d, e;
    int lat; bit ok; logic b0, bd;
    run_op(8'd12, 8'd12, 8'd13, d, lat, ok, b0, bd);
    e = exp_q.pop_front();
    n_chk++;
    if (!ok || (d !== e && d !== alt_of(e, 8'd13))) begin
      n_fail++;
      $display("FAIL final_sub: dout=%0d seen=%0d, required %0d or %0d", d, ok, e, alt_of(e, 8'd13));
    end
  endtask

  task automatic test_boundary;
    logic [W-1:0] d, e;
    int lat; bit ok; logic b0, bd;
    run_op(8'd254, 8'd254, 8'd255, d, lat, ok, b0, bd);
    e = exp_q.pop_front();
    n_chk++;
    if (!ok || (d !== e && d !== alt_of(e, 8'd255)) || e !== 8'd1) begin
      n_fail++;
      $display("FAIL boundary_max: dout=%0d seen=%0d, required %0d or %0d", d, ok, e, alt_of(e, 8'd255));
    end
    run_op(8'd0, 8'd200, 8'd255, d, lat, ok, b0, bd);
    e = exp_q.pop_front();
    n_chk++;
    if (!ok || d !== 8'd0 || e !== 8'd0) begin
      n_fail++;
      $display("FAIL boundary_zero: dout=%0d seen=%0d, required 0", d, ok);
    end
  endtask

  task automatic test_protocol;
    int exp_edges[$];
    int ndone, nexp;
    logic [W-1:0] e, prev;
    bit have_prev;
    @(negedge clk);
    a = 8'd5; b = 8'd7; m = 8'd13; start = 1'b1;
    for (int s = 0; s < 20; s += LAT + 1) begin
      exp_edges.push_back(s + LAT);
      exp_q.push_back(ref_mont(5, 7, 13));
    end
    nexp = exp_edges.size();
    ndone = 0; have_prev = 1'b0; prev = '0;
    for (int c = 0; c < 20 + LAT + 5; c++) begin
      @(posedge clk); #1;
      if (c == 19) start = 1'b0;
      if (done) begin
        ndone++;
        e = exp_q.pop_front();
        n_chk++;
        if (exp_edges.size() == 0 || c != exp_edges[0] || dout !== e) begin
          n_fail++;
          $display("FAIL proto_done: done at edge %0d dout=%0d, required edge %0d dout %0d",
                   c, dout, (exp_edges.size() != 0) ? exp_edges[0] : -1, e);
        end
        if (exp_edges.size() != 0) void'(exp_edges.pop_front());
        prev = e; have_prev = 1'b1;
      end else if (have_prev) begin
        n_chk++;
        if (dout !== prev) begin
          n_fail++;
          $display("FAIL proto_stable: dout=%0d at edge %0d, required %0d", dout, c, prev);
        end
      end
    end
    n_chk++;
    if (ndone != nexp) begin
      n_fail++;
      $display("FAIL proto_count: %0d done pulses, required %0d", ndone, nexp);
    end
  endtask

  task automatic test_latch;
    logic [W-1:0] e, d;
    bit ok;
    @(negedge clk);
    a = 8'd5; b = 8'd7; m = 8'd13; start = 1'b1;
    exp_q.push_back(ref_mont(5, 7, 13));
    @(posedge clk); #1;
    start = 1'b0;
    ok = 1'b0; d = '0;
    for (int k = 0; k < 40 && !ok; k++) begin
      @(posedge clk); #1;
      if (k == 2) begin a = 8'd12; b = 8'd11; end
      if (done) begin ok = 1'b1; d = dout; end
    end
    e = exp_q.pop_front();
    n_chk++;
    if (!ok || d !== e) begin
      n_fail++;
      $display("FAIL latch_operands: dout=%0d seen=%0d, required %0d", d, ok, e);
    end
  endtask

  task automatic test_reset_mid;
    logic [W-1:0] d, e;
    int lat, nd; bit ok; logic b0, bd;
    @(negedge clk);
    a = 8'd12; b = 8'd12; m = 8'd13; start = 1'b1;
    exp_q.push_back(ref_mont(12, 12, 13));
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    void'(exp_q.pop_back());
    n_chk++;
    if (dout !== 8'd0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: dout=%0d busy=%b done=%b, required 0/0/0", dout, busy, done);
    end
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    nd = 0;
    for (int k = 0; k < LAT + 3; k++) begin
      @(posedge clk); #1;
      if (done) nd++;
    end
    n_chk++;
    if (nd != 0) begin
      n_fail++;
      $display("FAIL reset_no_done: %0d done pulses after abort, required 0", nd);
    end
    run_op(8'd5, 8'd7, 8'd13, d, lat, ok, b0, bd);
    e = exp_q.pop_front();
    n_chk++;
    if (!ok || lat != LAT || d !== e) begin
      n_fail++;
      $display("FAIL reset_recover: dout=%0d lat=%0d seen=%0d, required %0d lat %0d", d, lat, ok, e, LAT);
    end
  endtask

  task automatic test_random;
    logic [W-1:0] d, e, rm, ra, rb;
    int lat; bit ok; logic b0, bd;
    for (int i = 0; i < 1000; i++) begin
      rm = W'($urandom_range(1, 127) * 2 + 1);
      ra = W'($urandom_range(0, int'(rm) - 1));
      rb = W'($urandom_range(0, int'(rm) - 1));
      run_op(ra, rb, rm, d, lat, ok, b0, bd);
      e = exp_q.pop_front();
      n_chk++;
      if (!ok || lat != LAT || (d !== e && d !== alt_of(e, rm))) begin
        n_fail++;
        $display("FAIL random_%0d: a=%0d b=%0d m=%0d dout=%0d lat=%0d, required %0d or %0d lat %0d",
                 i, ra, rb, rm, d, lat, e, alt_of(e, rm), LAT);
      end
      n_chk++;
`ifdef MMM_FINAL_SUB_EN
      if (int'(d) >= int'(rm)) begin
`else
      if (int'(d) >= 2 * int'(rm)) begin
`endif
        n_fail++;
        $display("FAIL random_bound_%0d: dout=%0d exceeds bound for m=%0d", i, d, rm);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_final_sub();
    test_boundary();
    test_protocol();
    test_latch();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
